// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared encodings for the Basys2 digital clock mode/time-set controller.
//   state_e       : FSM state, also the set_field code seen by the display mux
//   HOLD_TICKS_DEF: default number of tick_fast pulses ADJ must be held before
//                   auto-repeat starts (used only with CLOCK_CTRL_AUTOREPEAT_EN)
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_SET_SEC = 2'b11
    } state_e;

    localparam int unsigned HOLD_TICKS_DEF = 32'd4;

endpackage

// File: rtl/clock_ctrl_btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for an already-debounced button level.
//   CP    : system clock (rising edge)
//   CR    : synchronous active-high reset
//   level : debounced button level
//   rise  : high while level is 1 and the registered level is 0
// The level register resets to 1, so a button held through reset yields no edge.
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic CP,
    input  logic CR,
    input  logic level,
    output logic rise
);

    logic level_d;
    logic level_q;

    // next value of the level register is simply the current level
    always_comb begin
        level_d = level;
    end

    // level register, reset high
    always_ff @(posedge CP) begin
        if (CR) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
// Mode and time-set controller: steps RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
// on MODE rises, generates per-field count enables / seconds clear and the
// field-select and blink-visibility signals for the display mux.
// Optional feature macro: CLOCK_CTRL_AUTOREPEAT_EN (ADJ auto-repeat in
// SET_HR/SET_MIN after HOLD_TICKS tick_fast pulses of holding).
// Ports:
//   CP, CR            : clock, synchronous active-high reset
//   tick_1hz          : 1 Hz one-cycle pulse
//   tick_fast         : ~4 Hz one-cycle pulse (blink / repeat base)
//   mode_btn, adj_btn : debounced button levels
//   sec_max, min_max  : seconds / minutes counters at 59
//   en_sec/en_min/en_hr, sec_clr : registered one-cycle pulses
//   set_field         : current state code
//   field_vis         : 1 = selected field shown, 0 = blanked
// -----------------------------------------------------------------------------
module clock_ctrl
    import clock_pkg::*;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
#(
    parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF
)
`endif
(
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       mode_btn,
    input  logic       adj_btn,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hr,
    output logic       sec_clr,
    output logic [1:0] set_field,
    output logic       field_vis
);

    state_e state_d, state_q;
    logic   en_sec_d, en_sec_q;
    logic   en_min_d, en_min_q;
    logic   en_hr_d, en_hr_q;
    logic   sec_clr_d, sec_clr_q;
    logic   vis_d, vis_q;
    logic   mode_rise_s;
    logic   adj_rise_s;
    logic   adj_ok_s;
    logic   rpt_s;
    logic   adj_go_s;

    btn_edge u_mode_edge (
        .CP    (CP),
        .CR    (CR),
        .level (mode_btn),
        .rise  (mode_rise_s)
    );

    btn_edge u_adj_edge (
        .CP    (CP),
        .CR    (CR),
        .level (adj_btn),
        .rise  (adj_rise_s)
    );

    // a mode rise in the same cycle swallows the adj rise
    assign adj_ok_s = adj_rise_s & ~mode_rise_s;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(HOLD_TICKS + 1);

    logic [RPT_W-1:0] rpt_cnt_d, rpt_cnt_q;

    // hold counter: counts tick_fast while ADJ is held in SET_HR/SET_MIN,
    // saturates at HOLD_TICKS and then fires one repeat per tick_fast
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_s     = 1'b0;
        if (mode_rise_s || !adj_btn ||
            !((state_q == ST_SET_HR) || (state_q == ST_SET_MIN))) begin
            rpt_cnt_d = {RPT_W{1'b0}};
        end else if (tick_fast) begin
            if (rpt_cnt_q == RPT_W'(HOLD_TICKS)) begin
                rpt_s = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + {{(RPT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            rpt_cnt_d = rpt_cnt_q;
        end
    end

    // hold counter register
    always_ff @(posedge CP) begin
        if (CR) begin
            rpt_cnt_q <= {RPT_W{1'b0}};
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign rpt_s = 1'b0;
`endif

    // increment request for hours/minutes: manual rise or auto-repeat
    assign adj_go_s = adj_ok_s | rpt_s;

    // next state and pulse generation, evaluated against the current state
    always_comb begin
        state_d   = state_q;
        en_sec_d  = 1'b0;
        en_min_d  = 1'b0;
        en_hr_d   = 1'b0;
        sec_clr_d = 1'b0;
        if (mode_rise_s) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_SEC;
                ST_SET_SEC: state_d = ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end else begin
            state_d = state_q;
        end
        case (state_q)
            ST_RUN: begin
                en_sec_d = tick_1hz;
                en_min_d = tick_1hz & sec_max;
                en_hr_d  = tick_1hz & sec_max & min_max;
            end
            ST_SET_HR:  en_hr_d   = adj_go_s;
            ST_SET_MIN: en_min_d  = adj_go_s;
            ST_SET_SEC: sec_clr_d = adj_ok_s;
            default: begin
                en_sec_d = 1'b0;
            end
        endcase
    end

    // blink: solid in RUN and on entry / adjust, otherwise toggled by tick_fast
    always_comb begin
        vis_d = vis_q;
        if (mode_rise_s) begin
            vis_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            vis_d = 1'b1;
        end else if (adj_go_s) begin
            vis_d = 1'b1;
        end else if (tick_fast) begin
            vis_d = ~vis_q;
        end else begin
            vis_d = vis_q;
        end
    end

    // state and registered outputs
    always_ff @(posedge CP) begin
        if (CR) begin
            state_q   <= ST_RUN;
            en_sec_q  <= 1'b0;
            en_min_q  <= 1'b0;
            en_hr_q   <= 1'b0;
            sec_clr_q <= 1'b0;
            vis_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            en_sec_q  <= en_sec_d;
            en_min_q  <= en_min_d;
            en_hr_q   <= en_hr_d;
            sec_clr_q <= sec_clr_d;
            vis_q     <= vis_d;
        end
    end

    assign en_sec    = en_sec_q;
    assign en_min    = en_min_q;
    assign en_hr     = en_hr_q;
    assign sec_clr   = sec_clr_q;
    assign set_field = state_q;
    assign field_vis = vis_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_ctrl
// Scoreboard bench for clock_ctrl. The stimulus side pushes each expected
// pulse pattern {en_sec,en_min,en_hr,sec_clr} with the cycle it must appear in;
// a monitor pops and compares whenever any pulse output is high. Field select
// and visibility are checked directly at chosen points.
// -----------------------------------------------------------------------------
module tb_clock_ctrl;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_fast = 1'b0;
    logic       mode_btn = 1'b1;
    logic       adj_btn = 1'b0;
    logic       sec_max = 1'b0;
    logic       min_max = 1'b0;
    logic       en_sec, en_min, en_hr, sec_clr;
    logic [1:0] set_field;
    logic       field_vis;

    typedef struct {
        logic [3:0] p;
        int         stamp;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    logic mon_en = 1'b0;

    clock_ctrl dut (
        .CP        (CP),
        .CR        (CR),
        .tick_1hz  (tick_1hz),
        .tick_fast (tick_fast),
        .mode_btn  (mode_btn),
        .adj_btn   (adj_btn),
        .sec_max   (sec_max),
        .min_max   (min_max),
        .en_sec    (en_sec),
        .en_min    (en_min),
        .en_hr     (en_hr),
        .sec_clr   (sec_clr),
        .set_field (set_field),
        .field_vis (field_vis)
    );

    always #5 CP = ~CP;

    always @(posedge CP) cyc = cyc + 1;

    // monitor: every cycle with a pulse must match the head of the scoreboard
    always @(negedge CP) begin
        if (mon_en && (en_sec | en_min | en_hr | sec_clr)) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL extra_pulse cyc=%0d act=%b required=none", cyc,
                         {en_sec, en_min, en_hr, sec_clr});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (({en_sec, en_min, en_hr, sec_clr} !== e.p) || (cyc != e.stamp)) begin
                    bad = bad + 1;
                    $display("FAIL pulse act=%b@%0d required=%b@%0d",
                             {en_sec, en_min, en_hr, sec_clr}, cyc, e.p, e.stamp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic push(input logic [3:0] p);
        exp_t e;
        e.p     = p;
        e.stamp = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s act=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
    endtask

    task automatic press_adj(input logic [3:0] p, input logic expect_pulse);
        adj_btn = 1'b1;
        if (expect_pulse) push(p);
        step(1);
        adj_btn = 1'b0;
        step(1);
    endtask

    task automatic pulse_1hz(input logic [3:0] p, input logic expect_pulse);
        tick_1hz = 1'b1;
        if (expect_pulse) push(p);
        step(1);
        tick_1hz = 1'b0;
        step(2);
    endtask

    initial begin
        // reset with MODE held through it: no edge afterwards
        step(2);
        CR = 1'b0;
        mon_en = 1'b1;
        step(3);
        check("rst_field", {6'd0, set_field}, 8'h00);
        check("rst_vis", {7'd0, field_vis}, 8'h01);
        check("rst_en", {4'd0, en_sec, en_min, en_hr, sec_clr}, 8'h00);
        mode_btn = 1'b0;
        step(2);

        // RUN carry chain
        sec_max = 1'b1; min_max = 1'b1;
        pulse_1hz(4'b1110, 1'b1);
        min_max = 1'b0;
        pulse_1hz(4'b1100, 1'b1);
        sec_max = 1'b0;
        pulse_1hz(4'b1000, 1'b1);
        adj_btn = 1'b1; step(1); adj_btn = 1'b0; step(1);

        // enter SET_HR: time frozen, blink, adj forces visible
        press_mode();
        check("field_hr", {6'd0, set_field}, 8'h01);
        check("vis_entry", {7'd0, field_vis}, 8'h01);
        sec_max = 1'b1; min_max = 1'b1;
        pulse_1hz(4'b0000, 1'b0);
        sec_max = 1'b0; min_max = 1'b0;
        tick_fast = 1'b1; step(1); tick_fast = 1'b0;
        check("blink0", {7'd0, field_vis}, 8'h00);
        tick_fast = 1'b1; step(1); tick_fast = 1'b0;
        check("blink1", {7'd0, field_vis}, 8'h01);
        tick_fast = 1'b1; step(1); tick_fast = 1'b0;
        check("blink2", {7'd0, field_vis}, 8'h00);
        adj_btn = 1'b1; push(4'b0010); step(1); adj_btn = 1'b0;
        check("vis_adj", {7'd0, field_vis}, 8'h01);
        step(1);

        // SET_MIN: three adj rises, three en_min
        press_mode();
        check("field_min", {6'd0, set_field}, 8'h02);
        for (int i = 0; i < 3; i++) press_adj(4'b0100, 1'b1);

        // SET_SEC: adj clears seconds
        press_mode();
        check("field_sec", {6'd0, set_field}, 8'h03);
        press_adj(4'b0001, 1'b1);
        press_mode();
        check("field_run", {6'd0, set_field}, 8'h00);
        step(1);

        // collision in SET_HR: mode wins, no en_hr
        press_mode();
        step(1);
        mode_btn = 1'b1; adj_btn = 1'b1;
        step(1);
        mode_btn = 1'b0; adj_btn = 1'b0;
        check("collide_field", {6'd0, set_field}, 8'h02);
        step(1);
        press_mode(); step(1);
        press_mode();
        check("back_run", {6'd0, set_field}, 8'h00);
        step(1);

        // hold ADJ in SET_HR across 7 tick_fast pulses
        press_mode();
        step(1);
        adj_btn = 1'b1; push(4'b0010);
        step(1);
        for (int k = 1; k <= 7; k++) begin
            tick_fast = 1'b1;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
            if (k > 4) push(4'b0010);
`endif
            step(1);
            tick_fast = 1'b0;
            step(1);
        end
        adj_btn = 1'b0;
        step(2);
        check("hold_field", {6'd0, set_field}, 8'h01);

        // reset mid-set with a coincident adj rise: pulse suppressed
        adj_btn = 1'b1; CR = 1'b1;
        step(1);
        CR = 1'b0; adj_btn = 1'b0;
        check("midrst_field", {6'd0, set_field}, 8'h00);
        check("midrst_vis", {7'd0, field_vis}, 8'h01);
        step(4);

        check("sb_empty", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and time-set controller for the Basys2 digital clock. It takes the 1 Hz tick, debounced MODE/ADJ buttons and terminal-count flags from the seconds/minutes counter chain (mod-6/mod-10 digit counters). It generates the per-field count enables and the seconds clear, and steps the clock through RUN → SET_HR → SET_MIN → SET_SEC. It also drives the field-select and blink-visibility signals consumed by the display mux.

## Interface
- HOLD_TICKS, 4: tick_fast pulses ADJ must be held before auto-repeat starts (only with macro).
- CP  input  1  system clock; all logic on rising edge.
- CR  input  1  reset, synchronous, active-high.
- tick_1hz  input  1  one-CP-wide pulse, 1 Hz.
- tick_fast  input  1  one-CP-wide pulse, ~4 Hz (blink/repeat base).
- mode_btn  input  1  debounced MODE level.
- adj_btn  input  1  debounced ADJ level.
- sec_max  input  1  seconds counters currently at 59.
- min_max  input  1  minutes counters currently at 59.
- en_sec  output  1  seconds chain count enable, one cycle.
- en_min  output  1  minutes chain count enable, one cycle.
- en_hr  output  1  hours chain count enable, one cycle.
- sec_clr  output  1  seconds chain clear, one cycle.
- set_field  output  2  00 RUN, 01 hours, 10 minutes, 11 seconds.
- field_vis  output  1  1 = selected field displayed, 0 = blanked.

## Operation
- Edge detect on mode_btn/adj_btn: rise = level & ~level_q.
- FSM states RUN, SET_HR, SET_MIN, SET_SEC; set_field = state code.
- A mode rise advances the FSM RUN→SET_HR→SET_MIN→SET_SEC→RUN. Otherwise the state holds.
- RUN: en_sec = tick_1hz; en_min = tick_1hz & sec_max; en_hr = tick_1hz & sec_max & min_max. Adj is ignored.
- SET_HR: an adj rise pulses en_hr only. tick_1hz is ignored, so time is frozen.
- SET_MIN: an adj rise pulses en_min only. No carry into hours; the minute counters wrap 59→00 themselves.
- SET_SEC: an adj rise pulses sec_clr; en_sec stays 0.
- field_vis:
  - Always 1 in RUN.
  - In set states, toggles on each tick_fast.
  - Forced to 1 on state entry and on any adj-generated pulse.
- Simultaneous events:
  - Mode rise and adj rise in the same cycle: the mode rise wins and the adj is dropped.
  - tick_1hz coincident with a RUN→SET_HR transition is still applied, because RUN is the evaluated state.

## Timing
- All outputs are registered. Each enable/clear pulse appears exactly one CP cycle after the cycle in which the qualifying input (tick or button rise) is sampled, and lasts one cycle.
- set_field changes one cycle after the mode rise is sampled.
- Reset values:
  - state RUN, set_field 00
  - en_sec, en_min, en_hr, sec_clr = 0
  - field_vis = 1
  - edge registers = 1, so a button held through reset produces no edge
  - repeat counter = 0
- Reset mid-set returns to RUN in the next cycle. Any pulse pending that cycle is suppressed.
- Sustained button levels give no further pulses, except auto-repeat when enabled.

## Configuration
- CLOCK_CTRL_AUTOREPEAT_EN defined:
  - In SET_HR/SET_MIN, the controller counts tick_fast pulses while adj_btn is held.
  - After HOLD_TICKS pulses, each further tick_fast issues one increment pulse (en_hr or en_min).
  - Releasing adj_btn or changing state clears the counter.
  - SET_SEC never auto-repeats.
- Undefined: the repeat counter and its logic are absent; only adj rises generate pulses.

## Structure
- Shared package clock_pkg holds the state/set_field encodings (ST_RUN, ST_SET_HR, ST_SET_MIN, ST_SET_SEC) and the HOLD_TICKS default.
- One sub-module btn_edge (registered level plus rise output, reset value 1), instantiated for mode_btn and adj_btn.
- FSM, enable generation, blink and repeat logic live in clock_ctrl.

## Test plan
- Reset check: CR=1 for 2 cycles with mode_btn held at 1, then release CR → set_field=00, field_vis=1, all enables 0, and no state advance.
- RUN carry: sec_max=1, min_max=1, tick_1hz pulse → en_sec, en_min and en_hr all 1 for exactly one cycle, one cycle after the tick. Repeat with min_max=0 → en_hr stays 0.
- Mode cycling: 4 mode rises → set_field 01, 10, 11, 00. A tick_1hz during 01 → no enables.
- Adjust and collision:
  - In SET_MIN, 3 adj rises → 3 single en_min pulses and no en_hr.
  - In SET_SEC, an adj rise → one sec_clr pulse.
  - Mode and adj rising in the same cycle → state advances with no pulse.
- Blink: in SET_HR, field_vis toggles on each tick_fast, and an adj rise forces it to 1.
- Auto-repeat (macro on, HOLD_TICKS=4): hold adj for 7 tick_fast pulses in SET_HR → 1 rise pulse plus 3 repeat pulses on en_hr. With the macro off → 1 pulse.
